// File: rtl/attn_score_accum.sv
`timescale 1ns/1ps
// attn_score_accum: folds a stream of VEC_LEN FP32 element products into one
// score by driving an external FP32 adder (running sum on A, element on B).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// GET_FIRST | wait for element 0, load it straight into the accumulator
// GET_X     | wait for the next element, hold it for the B operand
// SEND_A    | offer the running sum to adder input A
// SEND_B    | offer the held element to adder input B
// WAIT_Z    | take the adder result back as the new running sum
// PUT_SCORE | offer the finished score until the consumer acks it
module attn_score_accum #(
    parameter int  VEC_LEN = 64,
    localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] add_a,
    output logic        add_a_stb,
    input  logic        add_a_ack,
    output logic [31:0] add_b,
    output logic        add_b_stb,
    input  logic        add_b_ack,
    input  logic [31:0] add_z,
    input  logic        add_z_stb,
    output logic        add_z_ack,
    output logic [31:0] score_z,
    output logic        score_stb,
    input  logic        score_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        GET_FIRST = 3'd0,
        GET_X     = 3'd1,
        SEND_A    = 3'd2,
        SEND_B    = 3'd3,
        WAIT_Z    = 3'd4,
        PUT_SCORE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] VEC_LEN_C = CNT_W'(VEC_LEN);

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_ack_q, in_ack_d;
    logic [31:0]      add_a_q, add_a_d;
    logic             add_a_stb_q, add_a_stb_d;
    logic [31:0]      add_b_q, add_b_d;
    logic             add_b_stb_q, add_b_stb_d;
    logic             add_z_ack_q, add_z_ack_d;
    logic [31:0]      score_z_q, score_z_d;
    logic             score_stb_q, score_stb_d;
    logic             busy_q, busy_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output logic. Every handshake output is raised
    // one cycle after entering its state and dropped on the transfer edge.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        in_ack_d    = in_ack_q;
        add_a_d     = add_a_q;
        add_a_stb_d = add_a_stb_q;
        add_b_d     = add_b_q;
        add_b_stb_d = add_b_stb_q;
        add_z_ack_d = add_z_ack_q;
        score_z_d   = score_z_q;
        score_stb_d = score_stb_q;
        busy_d      = busy_q;

        case (state_q)
            GET_FIRST: begin
                if (!in_ack_q) begin
                    in_ack_d = 1'b1;
                end else if (in_stb) begin
                    acc_d    = in_data;
                    cnt_d    = CNT_W'(1);
                    busy_d   = 1'b1;
                    in_ack_d = 1'b0;
                    // a single-element vector bypasses the adder entirely
                    state_d  = (VEC_LEN == 1) ? PUT_SCORE : GET_X;
                end
            end
            GET_X: begin
                if (!in_ack_q) begin
                    in_ack_d = 1'b1;
                end else if (in_stb) begin
                    x_d      = in_data;
                    in_ack_d = 1'b0;
                    state_d  = SEND_A;
                end
            end
            SEND_A: begin
                if (!add_a_stb_q) begin
                    add_a_stb_d = 1'b1;
                    add_a_d     = acc_q;
                end else if (add_a_ack) begin
                    add_a_stb_d = 1'b0;
                    state_d     = SEND_B;
                end
            end
            SEND_B: begin
                if (!add_b_stb_q) begin
                    add_b_stb_d = 1'b1;
                    add_b_d     = x_q;
                end else if (add_b_ack) begin
                    add_b_stb_d = 1'b0;
                    state_d     = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (!add_z_ack_q) begin
                    add_z_ack_d = 1'b1;
                end else if (add_z_stb) begin
                    acc_d       = add_z;
                    add_z_ack_d = 1'b0;
                    cnt_d       = cnt_inc;
                    state_d     = (cnt_inc == VEC_LEN_C) ? PUT_SCORE : GET_X;
                end
            end
            PUT_SCORE: begin
                if (!score_stb_q) begin
                    score_stb_d = 1'b1;
                    score_z_d   = acc_q;
                end else if (score_ack) begin
                    score_stb_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = GET_FIRST;
                end
            end
            default: begin
                state_d = GET_FIRST;
            end
        endcase
    end

    // State and output registers; reset discards any partial vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= GET_FIRST;
            acc_q       <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            in_ack_q    <= 1'b0;
            add_a_q     <= '0;
            add_a_stb_q <= 1'b0;
            add_b_q     <= '0;
            add_b_stb_q <= 1'b0;
            add_z_ack_q <= 1'b0;
            score_z_q   <= '0;
            score_stb_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            in_ack_q    <= in_ack_d;
            add_a_q     <= add_a_d;
            add_a_stb_q <= add_a_stb_d;
            add_b_q     <= add_b_d;
            add_b_stb_q <= add_b_stb_d;
            add_z_ack_q <= add_z_ack_d;
            score_z_q   <= score_z_d;
            score_stb_q <= score_stb_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ack    = in_ack_q;
    assign add_a     = add_a_q;
    assign add_a_stb = add_a_stb_q;
    assign add_b     = add_b_q;
    assign add_b_stb = add_b_stb_q;
    assign add_z_ack = add_z_ack_q;
    assign score_z   = score_z_q;
    assign score_stb = score_stb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_attn_score_accum.sv
`timescale 1ns/1ps
// Bench for attn_score_accum: three instances (VEC_LEN 4, 2, 1), each with a
// behavioural stb/ack adder that handles integer-valued FP32 and infinities.
module tb_attn_score_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data   [3];
    logic        in_stb    [3];
    logic        in_ack    [3];
    logic [31:0] add_a     [3];
    logic        add_a_stb [3];
    logic        add_a_ack [3];
    logic [31:0] add_b     [3];
    logic        add_b_stb [3];
    logic        add_b_ack [3];
    logic [31:0] add_z     [3];
    logic        add_z_stb [3];
    logic        add_z_ack [3];
    logic [31:0] score_z   [3];
    logic        score_stb [3];
    logic        score_ack [3];
    logic        busy      [3];

    int nvec = 0;
    int nmis = 0;

    // adder model state and transaction logs
    int          ad_st  [3];
    int          ad_dly [3];
    logic [31:0] ra [3];
    logic [31:0] rb [3];
    int          a_cnt [3] = '{0, 0, 0};
    int          b_cnt [3] = '{0, 0, 0};
    int          z_cnt [3] = '{0, 0, 0};
    logic [31:0] a_log [3][16];
    logic [31:0] b_log [3][16];
    int          viol = 0;
    int          ab_seen [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        attn_score_accum #(.VEC_LEN(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data[g]),
            .in_stb    (in_stb[g]),
            .in_ack    (in_ack[g]),
            .add_a     (add_a[g]),
            .add_a_stb (add_a_stb[g]),
            .add_a_ack (add_a_ack[g]),
            .add_b     (add_b[g]),
            .add_b_stb (add_b_stb[g]),
            .add_b_ack (add_b_ack[g]),
            .add_z     (add_z[g]),
            .add_z_stb (add_z_stb[g]),
            .add_z_ack (add_z_ack[g]),
            .score_z   (score_z[g]),
            .score_stb (score_stb[g]),
            .score_ack (score_ack[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] mag;
        int          p;
        logic        s;
        if (v == 0) return 32'h0;
        s   = (v < 0);
        mag = s ? 32'(-v) : 32'(v);
        p   = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        return {s, 8'(127 + p), 23'(mag << (23 - p))};
    endfunction

    function automatic int fp_to_int(input logic [31:0] b);
        int          e;
        logic [31:0] mag;
        e = int'(b[30:23]) - 127;
        if (b[30:23] == 8'd0 || e < 0) return 0;
        mag = {9'd1, b[22:0]} >> (23 - e);
        return b[31] ? -int'(mag) : int'(mag);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        return int_to_fp(fp_to_int(a) + fp_to_int(b));
    endfunction

    // behavioural adder: A handshake, B handshake, two-cycle latency, Z handshake
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                ad_st[k]     <= 0;
                ad_dly[k]    <= 0;
                ra[k]        <= '0;
                rb[k]        <= '0;
                add_a_ack[k] <= 1'b0;
                add_b_ack[k] <= 1'b0;
                add_z[k]     <= '0;
                add_z_stb[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                case (ad_st[k])
                    0: begin
                        if (!add_a_ack[k]) add_a_ack[k] <= 1'b1;
                        else if (add_a_stb[k]) begin
                            ra[k] <= add_a[k];
                            a_log[k][a_cnt[k] & 15] <= add_a[k];
                            a_cnt[k] <= a_cnt[k] + 1;
                            add_a_ack[k] <= 1'b0;
                            add_b_ack[k] <= 1'b1;
                            ad_st[k] <= 1;
                        end
                    end
                    1: begin
                        if (add_b_stb[k]) begin
                            rb[k] <= add_b[k];
                            b_log[k][b_cnt[k] & 15] <= add_b[k];
                            b_cnt[k] <= b_cnt[k] + 1;
                            add_b_ack[k] <= 1'b0;
                            ad_dly[k] <= 2;
                            ad_st[k] <= 2;
                        end
                    end
                    2: begin
                        if (ad_dly[k] == 0) begin
                            add_z[k]     <= fadd(ra[k], rb[k]);
                            add_z_stb[k] <= 1'b1;
                            ad_st[k]     <= 3;
                        end else begin
                            ad_dly[k] <= ad_dly[k] - 1;
                        end
                    end
                    default: begin
                        if (add_z_ack[k]) begin
                            add_z_stb[k] <= 1'b0;
                            z_cnt[k]     <= z_cnt[k] + 1;
                            ad_st[k]     <= 0;
                        end
                    end
                endcase
            end
        end
    end

    // protocol monitor: one adder handshake line at a time, in_ack exclusive
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if ((int'(add_a_stb[k]) + int'(add_b_stb[k]) + int'(add_z_ack[k])) > 1 ||
                (in_ack[k] && (add_a_stb[k] || add_b_stb[k] || add_z_ack[k] || score_stb[k])))
                viol <= viol + 1;
            if (add_a_stb[k] || add_b_stb[k]) ab_seen[k] <= ab_seen[k] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_elem(input int k, input logic [31:0] d, input bit gaps);
        int t;
        if (gaps) begin
            in_stb[k] = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data[k] = d;
        in_stb[k]  = 1'b1;
        t = 0;
        while (in_ack[k] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            nvec++; nmis++;
            $display("FAIL in_handshake[%0d]: got no in_ack, expected in_ack=1 within 300 cycles", k);
        end else begin
            @(posedge clk);
            #1;
        end
        in_stb[k] = 1'b0;
    endtask

    task automatic send_vec(input int k, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input int n, input bit gaps);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < n; i++) send_elem(k, e[i], gaps);
    endtask

    task automatic wait_score(input int k);
        int t;
        t = 0;
        while (score_stb[k] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            nvec++; nmis++;
            $display("FAIL score_wait[%0d]: got score_stb=0, expected score_stb=1 within 500 cycles", k);
        end
    endtask

    task automatic ack_score(input int k);
        score_ack[k] = 1'b1;
        @(posedge clk);
        #1;
        score_ack[k] = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if ({in_ack[k], add_a[k], add_a_stb[k], add_b[k], add_b_stb[k], add_z_ack[k],
                 score_z[k], score_stb[k], busy[k]} !== '0) begin
                nmis++;
                $display("FAIL reset_outputs[%0d]: got nonzero outputs (in_ack=%b a_stb=%b b_stb=%b score_stb=%b busy=%b), expected all 0",
                         k, in_ack[k], add_a_stb[k], add_b_stb[k], score_stb[k], busy[k]);
            end
        end
        rst = 1'b1;
        nvec++;
        if (in_ack[0] !== 1'b0) begin
            nmis++;
            $display("FAIL in_ack_release: got %b, expected 0 before first edge", in_ack[0]);
        end
        @(negedge clk);
        nvec++;
        if (in_ack[0] !== 1'b1) begin
            nmis++;
            $display("FAIL in_ack_rise: got %b, expected 1 one cycle after reset release", in_ack[0]);
        end
    endtask

    task automatic test_vec4;
        int a0, b0, z0;
        logic [31:0] exp_a [3];
        logic [31:0] exp_b [3];
        exp_a = '{32'h3F800000, 32'h40400000, 32'h40C00000};
        exp_b = '{32'h40000000, 32'h40400000, 32'h40800000};
        a0 = a_cnt[0]; b0 = b_cnt[0]; z0 = z_cnt[0];
        send_vec(0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 4, 1'b0);
        wait_score(0);
        nvec++;
        if (score_z[0] !== 32'h41200000) begin
            nmis++;
            $display("FAIL vec4_score: got %h, expected 41200000", score_z[0]);
        end
        nvec++;
        if (busy[0] !== 1'b1) begin
            nmis++;
            $display("FAIL vec4_busy_high: got %b, expected 1", busy[0]);
        end
        ack_score(0);
        nvec++;
        if (busy[0] !== 1'b0 || score_stb[0] !== 1'b0) begin
            nmis++;
            $display("FAIL vec4_release: got busy=%b score_stb=%b, expected 0 0", busy[0], score_stb[0]);
        end
        nvec++;
        if (a_cnt[0] - a0 != 3 || b_cnt[0] - b0 != 3 || z_cnt[0] - z0 != 3) begin
            nmis++;
            $display("FAIL vec4_txn_count: got a=%0d b=%0d z=%0d, expected 3 3 3",
                     a_cnt[0] - a0, b_cnt[0] - b0, z_cnt[0] - z0);
        end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (a_log[0][(a0 + i) & 15] !== exp_a[i] || b_log[0][(b0 + i) & 15] !== exp_b[i]) begin
                nmis++;
                $display("FAIL vec4_operands[%0d]: got A=%h B=%h, expected A=%h B=%h", i,
                         a_log[0][(a0 + i) & 15], b_log[0][(b0 + i) & 15], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_vec2;
        send_vec(1, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 2, 1'b0);
        wait_score(1);
        nvec++;
        if (score_z[1] !== 32'h00000000) begin
            nmis++;
            $display("FAIL vec2_cancel: got %h, expected 00000000", score_z[1]);
        end
        ack_score(1);
        send_vec(1, 32'h7F800000, 32'h3F800000, 32'h0, 32'h0, 2, 1'b0);
        wait_score(1);
        nvec++;
        if (score_z[1] !== 32'h7F800000) begin
            nmis++;
            $display("FAIL vec2_inf: got %h, expected 7F800000", score_z[1]);
        end
        ack_score(1);
    endtask

    task automatic test_vec1;
        int s0;
        s0 = ab_seen[2];
        send_vec(2, 32'hC0490FDB, 32'h0, 32'h0, 32'h0, 1, 1'b0);
        wait_score(2);
        nvec++;
        if (score_z[2] !== 32'hC0490FDB) begin
            nmis++;
            $display("FAIL vec1_passthru: got %h, expected C0490FDB", score_z[2]);
        end
        ack_score(2);
        @(negedge clk);
        nvec++;
        if (ab_seen[2] != s0) begin
            nmis++;
            $display("FAIL vec1_no_adder: got %0d cycles with add stb, expected 0", ab_seen[2] - s0);
        end
    endtask

    task automatic test_backpressure;
        send_vec(0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 4, 1'b0);
        wait_score(0);
        in_data[0] = 32'h40A00000;
        in_stb[0]  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            nvec++;
            if (in_ack[0] !== 1'b0 || score_stb[0] !== 1'b1 || score_z[0] !== 32'h41200000) begin
                nmis++;
                $display("FAIL backpressure[%0d]: got in_ack=%b score_stb=%b score_z=%h, expected 0 1 41200000",
                         c, in_ack[0], score_stb[0], score_z[0]);
            end
        end
        ack_score(0);
        send_vec(0, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 4, 1'b0);
        wait_score(0);
        nvec++;
        if (score_z[0] !== 32'h41D00000) begin
            nmis++;
            $display("FAIL backpressure_next: got %h, expected 41D00000", score_z[0]);
        end
        ack_score(0);
    endtask

    task automatic test_gaps;
        int v [4];
        int sum;
        for (int n = 0; n < 100; n++) begin
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                v[i] = int'($urandom_range(0, 100)) - 50;
                sum += v[i];
            end
            send_vec(0, int_to_fp(v[0]), int_to_fp(v[1]), int_to_fp(v[2]), int_to_fp(v[3]), 4, 1'b1);
            wait_score(0);
            nvec++;
            if (score_z[0] !== int_to_fp(sum)) begin
                nmis++;
                $display("FAIL gaps_score[%0d]: got %h, expected %h (sum %0d)", n, score_z[0],
                         int_to_fp(sum), sum);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ack_score(0);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        send_vec(0, 32'h3F800000, 32'h40000000, 32'h0, 32'h0, 2, 1'b0);
        t = 0;
        @(negedge clk);
        while (add_b_stb[0] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        nvec++;
        if (t >= 50) begin
            nmis++;
            $display("FAIL mid_reach_send_b: got add_b_stb=0, expected 1 within 50 cycles");
        end
        rst = 1'b0;
        #1;
        nvec++;
        if ({in_ack[0], add_a[0], add_a_stb[0], add_b[0], add_b_stb[0], add_z_ack[0],
             score_z[0], score_stb[0], busy[0]} !== '0) begin
            nmis++;
            $display("FAIL mid_reset_outputs: got add_b=%h add_b_stb=%b busy=%b, expected all outputs 0",
                     add_b[0], add_b_stb[0], busy[0]);
        end
        #1;
        rst = 1'b1;
        send_vec(0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 4, 1'b0);
        wait_score(0);
        nvec++;
        if (score_z[0] !== 32'h41200000) begin
            nmis++;
            $display("FAIL mid_reset_recover: got %h, expected 41200000", score_z[0]);
        end
        ack_score(0);
    endtask

    task automatic test_protocol;
        nvec++;
        if (viol != 0) begin
            nmis++;
            $display("FAIL protocol_exclusive: got %0d violating cycles, expected 0", viol);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_data[k]   = '0;
            in_stb[k]    = 1'b0;
            score_ack[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset;
        test_vec4;
        test_vec2;
        test_vec1;
        test_backpressure;
        test_gaps;
        test_reset_mid;
        test_protocol;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
